// File: rtl/adc_3.sv
// Serial ADC frame receiver: captures 16-bit MSB-first frames while CS is low
// and presents the low 12 bits as the converted sample, one conversion per CS window.
//
// state    | meaning
// IDLE     | waiting for CS low; first low edge captures bit 1
// RECEIVE  | shifting bits 2..16 of the frame
// DONE     | one-cycle completion, rx_done_tick high
// WAIT_CS  | frame consumed, ignoring SCLK until CS returns high
module adc_3 (
    input  logic        SCLK,
    input  logic        reset,
    input  logic        CS,
    input  logic        SDATA,
    output logic        rx_done_tick,
    output logic [15:0] b_reg,
    output logic [11:0] data_Out
);

    typedef enum logic [1:0] {IDLE, RECEIVE, DONE, WAIT_CS} state_t;

    state_t      state, state_next;
    logic [3:0]  n, n_next;
    logic [15:0] b_next;
    logic [11:0] data_next;

    always_ff @(posedge SCLK) begin
        if (reset) begin
            state        <= IDLE;
            n            <= 4'd0;
            b_reg        <= 16'h0000;
            data_Out     <= 12'h000;
            rx_done_tick <= 1'b0;
        end else begin
            state        <= state_next;
            n            <= n_next;
            b_reg        <= b_next;
            data_Out     <= data_next;
            // Registered copy of the Moore output so the tick leaves a flop
            rx_done_tick <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next = state;
        n_next     = n;
        b_next     = b_reg;
        data_next  = data_Out;
        case (state)
            IDLE: begin
                if (!CS) begin
                    b_next     = {b_reg[14:0], SDATA};
                    n_next     = 4'd1;
                    state_next = RECEIVE;
                end
            end
            RECEIVE: begin
                if (CS) begin
                    n_next     = 4'd0;
                    state_next = IDLE;
                end else begin
                    b_next = {b_reg[14:0], SDATA};
                    if (n == 4'd15) begin
                        n_next     = 4'd0;
                        data_next  = {b_reg[10:0], SDATA};
                        state_next = DONE;
                    end else begin
                        n_next = n + 4'd1;
                    end
                end
            end
            DONE: begin
                state_next = CS ? IDLE : WAIT_CS;
            end
            WAIT_CS: begin
                if (CS) state_next = IDLE;
            end
            default: begin
                n_next     = 4'd0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adc_3.sv
// Bench for adc_3: table of frames, hand-written corner sequences and random
// traffic, all compared every cycle against a frame-level reference model.
module tb_adc_3;

    logic        SCLK = 1'b0;
    logic        reset = 1'b1;
    logic        CS = 1'b1;
    logic        SDATA = 1'b0;
    logic        rx_done_tick;
    logic [15:0] b_reg;
    logic [11:0] data_Out;

    adc_3 dut (
        .SCLK(SCLK),
        .reset(reset),
        .CS(CS),
        .SDATA(SDATA),
        .rx_done_tick(rx_done_tick),
        .b_reg(b_reg),
        .data_Out(data_Out)
    );

    always #5 SCLK = ~SCLK;

    int total = 0;
    int bad   = 0;

    // reference model: bits captured in this CS window, and whether the window
    // has already produced its one conversion
    logic [15:0] m_b = 16'h0000;
    logic [11:0] m_data = 12'h000;
    logic        m_tick = 1'b0;
    int          m_k = 0;
    bit          m_used = 1'b0;

    int tick_cnt = 0;
    int step_idx = 0;
    int first_tick_step = -1;

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        int          extra_low;
        logic [15:0] exp_b;
        logic [11:0] exp_data;
        int          exp_ticks;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic cs, input logic sd);
        @(negedge SCLK);
        reset = rst;
        CS    = cs;
        SDATA = sd;
        @(posedge SCLK);
        #1;
        if (rst) begin
            m_b = 16'h0000; m_data = 12'h000; m_tick = 1'b0; m_k = 0; m_used = 1'b0;
        end else begin
            m_tick = 1'b0;
            if (cs) begin
                m_k = 0;
                m_used = 1'b0;
            end else if (!m_used) begin
                m_b = {m_b[14:0], sd};
                m_k++;
                if (m_k == 16) begin
                    m_data = m_b[11:0];
                    m_tick = 1'b1;
                    m_used = 1'b1;
                    m_k = 0;
                end
            end
        end
        step_idx++;
        if (rx_done_tick === 1'b1) begin
            tick_cnt++;
            if (first_tick_step < 0) first_tick_step = step_idx;
        end
        chk("b_reg", {16'h0, b_reg}, {16'h0, m_b});
        chk("data_Out", {20'h0, data_Out}, {20'h0, m_data});
        chk("rx_done_tick", {31'h0, rx_done_tick}, {31'h0, m_tick});
    endtask

    // Sends nbits of frame MSB first, extra_low random bits with CS still low,
    // then one CS-high cycle closing the window.
    task automatic send_frame(input logic [15:0] frame, input int nbits, input int extra_low);
        tick_cnt = 0;
        step_idx = 0;
        first_tick_step = -1;
        for (int i = 0; i < nbits; i++) step(1'b0, 1'b0, frame[15-i]);
        for (int i = 0; i < extra_low; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        vecs[0] = '{16'h0ABC, 16, 0, 16'h0ABC, 12'hABC, 1};
        vecs[1] = '{16'hF123, 16, 0, 16'hF123, 12'h123, 1};
        vecs[2] = '{16'hA5A5,  8, 0, 16'h23A5, 12'h123, 0};
        vecs[3] = '{16'h0555, 16, 0, 16'h0555, 12'h555, 1};
        vecs[4] = '{16'h0C3A, 16, 6, 16'h0C3A, 12'hC3A, 1};
        vecs[5] = '{16'h0123, 16, 0, 16'h0123, 12'h123, 1};

        // reset held with CS low and SDATA toggling
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'(i % 2));
            chk("reset_b_reg", {16'h0, b_reg}, 32'h0);
            chk("reset_data", {20'h0, data_Out}, 32'h0);
            chk("reset_tick", {31'h0, rx_done_tick}, 32'h0);
        end
        step(1'b0, 1'b1, 1'b0);

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].frame, vecs[v].nbits, vecs[v].extra_low);
            chk("vec_b_reg", {16'h0, b_reg}, {16'h0, vecs[v].exp_b});
            chk("vec_data", {20'h0, data_Out}, {20'h0, vecs[v].exp_data});
            chk("vec_ticks", tick_cnt, vecs[v].exp_ticks);
            if (vecs[v].exp_ticks == 1) chk("vec_latency", first_tick_step, 16);
        end

        // reset arriving at bit 10 of a frame
        tick_cnt = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'(i % 3 == 0));
        step(1'b1, 1'b0, 1'b1);
        chk("midreset_b_reg", {16'h0, b_reg}, 32'h0);
        chk("midreset_data", {20'h0, data_Out}, 32'h0);
        chk("midreset_ticks", tick_cnt, 0);
        send_frame(16'h0FFF, 16, 0);
        chk("after_reset_data", {20'h0, data_Out}, 32'hFFF);
        chk("after_reset_ticks", tick_cnt, 1);
        chk("after_reset_latency", first_tick_step, 16);

        // random traffic, model-checked every cycle
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 14) == 0),
                 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
